// File: rtl/conv_pkg.sv
// Shared types and geometry helpers for the conv layer writeback path.
package conv_pkg;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BANK,
        S_RUN,
        S_DONE
    } state_t;

    function automatic int ofm_size(input int ifm, input int k);
        return ifm - k + 1;
    endfunction

    // Pixel count of one output map for the default 32x32 input, 5x5 kernel layer
    localparam int OFM_PIXELS = ofm_size(32, 5) * ofm_size(32, 5);

endpackage

// File: rtl/conv_ofm_writeback.sv
// Scatters a pixel-major, filter-innermost result stream into per-filter IFM banks.
// Define CONV_OFM_PINGPONG_EN for a double-buffered bank select gated by i_next_bank_free.
module conv_ofm_writeback
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH        = 32,
    parameter int IFM_SIZE          = 32,
    parameter int KERNAL_SIZE       = 5,
    parameter int NUMBER_OF_FILTERS = 15,
    parameter int ADDRESS_SIZE_OFM  = $clog2((IFM_SIZE - KERNAL_SIZE + 1) * (IFM_SIZE - KERNAL_SIZE + 1))
) (
    input  logic                         i_clk,
    input  logic                         i_reset,
    input  logic                         i_frame_start,
    input  logic                         i_in_valid,
    input  logic [DATA_WIDTH-1:0]        i_data_in,
`ifdef CONV_OFM_PINGPONG_EN
    input  logic [1:0]                   i_next_bank_free,
    output logic [ADDRESS_SIZE_OFM:0]    o_ofm_address,
`else
    output logic [ADDRESS_SIZE_OFM-1:0]  o_ofm_address,
`endif
    output logic [DATA_WIDTH-1:0]        o_ofm_data,
    output logic [NUMBER_OF_FILTERS-1:0] o_ofm_enable_write,
    output logic                         o_busy,
    output logic                         o_frame_done,
    output logic                         o_error
);

    localparam int OFM_SIZE = ofm_size(IFM_SIZE, KERNAL_SIZE);
    localparam int FW       = (NUMBER_OF_FILTERS > 1) ? $clog2(NUMBER_OF_FILTERS) : 1;
    localparam int CW       = (OFM_SIZE > 1) ? $clog2(OFM_SIZE) : 1;

    localparam logic [FW-1:0]               FILT_LAST = FW'(NUMBER_OF_FILTERS - 1);
    localparam logic [CW-1:0]               POS_LAST  = CW'(OFM_SIZE - 1);
    localparam logic [ADDRESS_SIZE_OFM-1:0] ROW_STEP  = ADDRESS_SIZE_OFM'(OFM_SIZE);

    state_t                         r_state;
    logic [FW-1:0]                  r_filt;
    logic [CW-1:0]                  r_col;
    logic [CW-1:0]                  r_row;
    logic [ADDRESS_SIZE_OFM-1:0]    r_base;
    logic [DATA_WIDTH-1:0]          r_ofm_data;
    logic [ADDRESS_SIZE_OFM-1:0]    r_ofm_address;
    logic [NUMBER_OF_FILTERS-1:0]   r_ofm_enable_write;
    logic                           r_busy;
    logic                           r_frame_done;
    logic                           r_error;

    logic [ADDRESS_SIZE_OFM-1:0]    w_pixel_addr;
    logic                           w_last_filt;
    logic                           w_last_pixel;
    logic                           w_bank_ready;

    // r_base tracks row*OFM_SIZE so the pixel address needs only an adder
    assign w_pixel_addr = r_base + ADDRESS_SIZE_OFM'(r_col);
    assign w_last_filt  = (r_filt == FILT_LAST);
    assign w_last_pixel = (r_row == POS_LAST) && (r_col == POS_LAST);

`ifdef CONV_OFM_PINGPONG_EN
    logic r_bank;
    assign w_bank_ready  = i_next_bank_free[r_bank];
    assign o_ofm_address = {r_bank, r_ofm_address};
`else
    assign w_bank_ready  = 1'b1;
    assign o_ofm_address = r_ofm_address;
`endif

    assign o_ofm_data         = r_ofm_data;
    assign o_ofm_enable_write = r_ofm_enable_write;
    assign o_busy             = r_busy;
    assign o_frame_done       = r_frame_done;
    assign o_error            = r_error;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state            <= S_IDLE;
            r_filt             <= '0;
            r_col              <= '0;
            r_row              <= '0;
            r_base             <= '0;
            r_ofm_data         <= '0;
            r_ofm_address      <= '0;
            r_ofm_enable_write <= '0;
            r_busy             <= 1'b0;
            r_frame_done       <= 1'b0;
            r_error            <= 1'b0;
`ifdef CONV_OFM_PINGPONG_EN
            r_bank             <= 1'b0;
`endif
        end else begin
            r_ofm_enable_write <= '0;
            r_frame_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_in_valid) begin
                        r_error <= 1'b1;
                    end
                    if (i_frame_start) begin
                        r_busy <= 1'b1;
                        if (w_bank_ready) begin
                            r_filt  <= '0;
                            r_col   <= '0;
                            r_row   <= '0;
                            r_base  <= '0;
                            r_state <= S_RUN;
                        end else begin
                            r_state <= S_WAIT_BANK;
                        end
                    end
                end
                S_WAIT_BANK: begin
                    if (i_in_valid || i_frame_start) begin
                        r_error <= 1'b1;
                    end
                    if (w_bank_ready) begin
                        r_filt  <= '0;
                        r_col   <= '0;
                        r_row   <= '0;
                        r_base  <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (i_frame_start) begin
                        r_error <= 1'b1;
                    end
                    if (i_in_valid) begin
                        r_ofm_data         <= i_data_in;
                        r_ofm_address      <= w_pixel_addr;
                        r_ofm_enable_write <= NUMBER_OF_FILTERS'(1) << r_filt;
                        if (w_last_filt && w_last_pixel) begin
                            r_frame_done <= 1'b1;
                            r_state      <= S_DONE;
                        end else if (!w_last_filt) begin
                            r_filt <= r_filt + FW'(1);
                        end else begin
                            r_filt <= '0;
                            if (r_col == POS_LAST) begin
                                r_col  <= '0;
                                r_row  <= r_row + CW'(1);
                                r_base <= r_base + ROW_STEP;
                            end else begin
                                r_col <= r_col + CW'(1);
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (i_in_valid || i_frame_start) begin
                        r_error <= 1'b1;
                    end
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
`ifdef CONV_OFM_PINGPONG_EN
                    r_bank  <= ~r_bank;
`endif
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule
